// File: rtl/fa_chk_pkg.sv
// Shared types and widths for the full-adder response checker.
// The first_err record holds the stimulus and the golden response for that stimulus.
package fa_chk_pkg;

   localparam int COV_W = 8;
   localparam int CNT_W = 8;
   localparam int FE_W  = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Packs as {a,b,cin,sum,carry}; sum/carry are the values the adder should have produced.
   typedef struct packed {
      logic a;
      logic b;
      logic cin;
      logic sum;
      logic carry;
   } first_err_t;

endpackage

// File: rtl/fa_golden.sv
// Reference full adder, purely combinational; zero latency, no flow control.
module fa_golden (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic exp_sum,
   output logic exp_carry
);

   assign exp_sum   = a ^ b ^ cin;
   assign exp_carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_resp_checker.sv
// Scores full-adder responses against a golden model over a run; all outputs registered,
// one-cycle latency from the accepting edge, no backpressure (every valid observation in RUN is taken).
module fa_resp_checker
   import fa_chk_pkg::*;
#(
   parameter int MAX_OBS = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       obs_valid,
   input  logic       obs_a,
   input  logic       obs_b,
   input  logic       obs_cin,
   input  logic       obs_sum,
   input  logic       obs_carry,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [7:0] cov_mask,
   output logic [4:0] first_err
);

   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OBS);
   localparam logic [COV_W-1:0] FULL_COV = {COV_W{1'b1}};
   localparam logic [7:0]       ERR_SAT  = 8'hFF;

   state_e            state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [7:0]        err_q, err_d;
   logic [COV_W-1:0]  cov_q, cov_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   first_err_t        ferr_q, ferr_d;

   logic              exp_sum;
   logic              exp_carry;
   logic              mismatch;
   logic [2:0]        obs_idx;

   fa_golden u_golden (
      .a         (obs_a),
      .b         (obs_b),
      .cin       (obs_cin),
      .exp_sum   (exp_sum),
      .exp_carry (exp_carry)
   );

   assign mismatch = (obs_sum != exp_sum) || (obs_carry != exp_carry);
   assign obs_idx  = {obs_a, obs_b, obs_cin};

   always_comb begin
      state_d = state_q;
      pass_d  = pass_q;
      err_d   = err_q;
      cov_d   = cov_q;
      cnt_d   = cnt_q;
      ferr_d  = ferr_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               pass_d  = 1'b0;
               err_d   = '0;
               cov_d   = '0;
               cnt_d   = '0;
               ferr_d  = '0;
            end
         end
         ST_RUN: begin
            // start is deliberately not looked at here: a run cannot be restarted mid-flight
            if (obs_valid) begin
               cnt_d = cnt_q + CNT_W'(1);
               cov_d = cov_q | (COV_W'(1) << obs_idx);
               if (mismatch) begin
                  if (err_q != ERR_SAT) begin
                     err_d = err_q + 8'd1;
                  end
                  if (err_q == 8'd0) begin
                     ferr_d.a     = obs_a;
                     ferr_d.b     = obs_b;
                     ferr_d.cin   = obs_cin;
                     ferr_d.sum   = exp_sum;
                     ferr_d.carry = exp_carry;
                  end
               end
               if ((cov_d == FULL_COV) || (cnt_d == MAX_CNT)) begin
                  state_d = ST_DONE;
                  pass_d  = (err_d == 8'd0) && (cov_d == FULL_COV);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            pass_d  = 1'b0;
         end
      endcase

      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         cov_q   <= '0;
         cnt_q   <= '0;
         ferr_q  <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         cov_q   <= cov_d;
         cnt_q   <= cnt_d;
         ferr_q  <= ferr_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign cov_mask  = cov_q;
   assign first_err = ferr_q;

endmodule

// File: tb/tb_fa_resp_checker.sv
// Directed bench: a vector table for the default-limit checker plus hand sequences for short and long limits.
module tb_fa_resp_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       obs_valid = 1'b0;
   logic       obs_a = 1'b0, obs_b = 1'b0, obs_cin = 1'b0;
   logic       obs_sum = 1'b0, obs_carry = 1'b0;

   logic       busy64, done64, pass64;
   logic [7:0] err64, cov64;
   logic [4:0] ferr64;
   logic       busy8, done8, pass8;
   logic [7:0] err8, cov8;
   logic [4:0] ferr8;
   logic       busy255, done255, pass255;
   logic [7:0] err255, cov255;
   logic [4:0] ferr255;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   fa_resp_checker #(.MAX_OBS(64)) u_d64 (
      .clk(clk), .rst_n(rst_n), .start(start), .obs_valid(obs_valid),
      .obs_a(obs_a), .obs_b(obs_b), .obs_cin(obs_cin),
      .obs_sum(obs_sum), .obs_carry(obs_carry),
      .busy(busy64), .done(done64), .pass(pass64),
      .err_count(err64), .cov_mask(cov64), .first_err(ferr64)
   );

   fa_resp_checker #(.MAX_OBS(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .start(start), .obs_valid(obs_valid),
      .obs_a(obs_a), .obs_b(obs_b), .obs_cin(obs_cin),
      .obs_sum(obs_sum), .obs_carry(obs_carry),
      .busy(busy8), .done(done8), .pass(pass8),
      .err_count(err8), .cov_mask(cov8), .first_err(ferr8)
   );

   fa_resp_checker #(.MAX_OBS(255)) u_d255 (
      .clk(clk), .rst_n(rst_n), .start(start), .obs_valid(obs_valid),
      .obs_a(obs_a), .obs_b(obs_b), .obs_cin(obs_cin),
      .obs_sum(obs_sum), .obs_carry(obs_carry),
      .busy(busy255), .done(done255), .pass(pass255),
      .err_count(err255), .cov_mask(cov255), .first_err(ferr255)
   );

   typedef struct {
      logic       rst_n;
      logic       start;
      logic       vld;
      logic [2:0] abc;
      logic       s;
      logic       c;
      logic       busy;
      logic       done;
      logic       pass;
      logic [7:0] err;
      logic [7:0] cov;
      logic [4:0] ferr;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic st, input logic v, input logic [2:0] abc,
                      input logic s, input logic c, input logic eb, input logic ed,
                      input logic ep, input logic [7:0] ee, input logic [7:0] ec,
                      input logic [4:0] ef);
      vec_t t;
      t.rst_n = r;  t.start = st; t.vld = v; t.abc = abc; t.s = s; t.c = c;
      t.busy = eb;  t.done = ed;  t.pass = ep; t.err = ee; t.cov = ec; t.ferr = ef;
      vq.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic st, input logic v, input logic [2:0] abc,
                        input logic s, input logic c);
      rst_n = r; start = st; obs_valid = v;
      {obs_a, obs_b, obs_cin} = abc;
      obs_sum = s; obs_carry = c;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] sum_t   = 8'b1001_0110;
   logic [7:0] carry_t = 8'b1110_1000;

   initial begin
      logic [7:0] cm;

      // reset, then an observation while IDLE must not register
      add(0,0,0,3'd0,0,0, 0,0,0,8'h00,8'h00,5'b0);
      add(1,0,1,3'd7,1,1, 0,0,0,8'h00,8'h00,5'b0);
      add(1,1,0,3'd0,0,0, 1,0,0,8'h00,8'h00,5'b0);
      cm = 8'h00;
      for (int k = 0; k < 8; k++) begin
         cm = (cm << 1) | 8'h01;
         add(1,0,1,3'(k),sum_t[k],carry_t[k], k != 7, k == 7, k == 7, 8'h00, cm, 5'b0);
      end
      // DONE holds through a stray mismatching observation and an idle cycle
      add(1,0,1,3'd0,1,0, 0,1,1,8'h00,8'hFF,5'b0);
      add(1,0,0,3'd0,0,0, 0,1,1,8'h00,8'hFF,5'b0);
      add(1,1,0,3'd0,0,0, 1,0,0,8'h00,8'h00,5'b0);
      cm = 8'h00;
      for (int k = 0; k < 8; k++) begin
         cm = (cm << 1) | 8'h01;
         add(1,0,1,3'(k),sum_t[k],carry_t[k] ^ (k == 6), k != 7, k == 7, 1'b0,
             (k >= 6) ? 8'h01 : 8'h00, cm, (k >= 6) ? 5'b11001 : 5'b00000);
      end
      // restart clears errors; start inside RUN is ignored, even alongside an observation
      add(1,1,0,3'd0,0,0, 1,0,0,8'h00,8'h00,5'b0);
      add(1,0,1,3'd0,0,0, 1,0,0,8'h00,8'h01,5'b0);
      add(1,0,1,3'd1,1,0, 1,0,0,8'h00,8'h03,5'b0);
      add(1,0,1,3'd2,1,0, 1,0,0,8'h00,8'h07,5'b0);
      add(1,1,0,3'd0,0,0, 1,0,0,8'h00,8'h07,5'b0);
      add(1,1,1,3'd3,0,1, 1,0,0,8'h00,8'h0F,5'b0);
      // reset beats start and obs_valid mid-run
      add(0,1,1,3'd4,1,0, 0,0,0,8'h00,8'h00,5'b0);
      add(1,0,0,3'd0,0,0, 0,0,0,8'h00,8'h00,5'b0);
      add(1,1,0,3'd0,0,0, 1,0,0,8'h00,8'h00,5'b0);
      cm = 8'h00;
      for (int k = 0; k < 8; k++) begin
         cm = (cm << 1) | 8'h01;
         add(1,0,1,3'(k),sum_t[k],carry_t[k], k != 7, k == 7, k == 7, 8'h00, cm, 5'b0);
      end
      // first_err keeps the first mismatch only
      add(1,1,0,3'd0,0,0, 1,0,0,8'h00,8'h00,5'b0);
      add(1,0,1,3'd2,0,0, 1,0,0,8'h01,8'h04,5'b01010);
      add(1,0,1,3'd5,0,0, 1,0,0,8'h02,8'h24,5'b01010);
      add(1,0,1,3'd1,1,0, 1,0,0,8'h02,8'h26,5'b01010);

      foreach (vq[i]) begin
         drive(vq[i].rst_n, vq[i].start, vq[i].vld, vq[i].abc, vq[i].s, vq[i].c);
         cyc();
         chk($sformatf("v%0d busy", i), {7'd0, busy64}, {7'd0, vq[i].busy});
         chk($sformatf("v%0d done", i), {7'd0, done64}, {7'd0, vq[i].done});
         chk($sformatf("v%0d pass", i), {7'd0, pass64}, {7'd0, vq[i].pass});
         chk($sformatf("v%0d err_count", i), err64, vq[i].err);
         chk($sformatf("v%0d cov_mask", i), cov64, vq[i].cov);
         chk($sformatf("v%0d first_err", i), {3'd0, ferr64}, {3'd0, vq[i].ferr});
      end

      // observation limit of 8 with only {0,0,0} seen
      drive(0,0,0,3'd0,0,0); cyc();
      drive(1,1,0,3'd0,0,0); cyc();
      drive(1,0,1,3'd0,0,0);
      for (int i = 1; i <= 8; i++) begin
         cyc();
         if (i == 7) begin
            chk("lim8 busy@7", {7'd0, busy8}, 8'd1);
            chk("lim8 done@7", {7'd0, done8}, 8'd0);
         end
         if (i == 8) begin
            chk("lim8 done@8", {7'd0, done8}, 8'd1);
            chk("lim8 busy@8", {7'd0, busy8}, 8'd0);
            chk("lim8 cov@8", cov8, 8'h01);
            chk("lim8 pass@8", {7'd0, pass8}, 8'd0);
            chk("lim8 err@8", err8, 8'h00);
            chk("lim64 busy@8", {7'd0, busy64}, 8'd1);
         end
      end
      drive(1,0,0,3'd0,0,0); cyc();
      chk("lim8 hold cov", cov8, 8'h01);

      // 300 mismatching observations against a limit of 255
      drive(0,0,0,3'd0,0,0); cyc();
      drive(1,1,0,3'd0,0,0); cyc();
      drive(1,0,1,3'd0,1,0);
      for (int i = 1; i <= 300; i++) begin
         cyc();
         if (i == 8) begin
            chk("lim8 errs@8", err8, 8'h08);
            chk("lim8 ferr@8", {3'd0, ferr8}, 8'h00);
         end
         if (i == 254) begin
            chk("lim255 busy@254", {7'd0, busy255}, 8'd1);
            chk("lim255 err@254", err255, 8'hFE);
         end
         if (i == 255) begin
            chk("lim255 done@255", {7'd0, done255}, 8'd1);
            chk("lim255 err@255", err255, 8'hFF);
            chk("lim255 pass@255", {7'd0, pass255}, 8'd0);
            chk("lim255 cov@255", cov255, 8'h01);
         end
         if (i == 300) begin
            chk("lim255 err@300", err255, 8'hFF);
            chk("lim255 done@300", {7'd0, done255}, 8'd1);
            chk("lim255 ferr@300", {3'd0, ferr255}, 8'h00);
         end
      end
      drive(1,0,0,3'd0,0,0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
